seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_mul_iter.sv | 70 +++++++
 rtl/seq_alu.sv | 151 +++++++++++++++
 tb/tb_seq_alu.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU.
//   alu_op_e    : 3-bit opcode carried on seq_alu.alu_op
//   alu_state_e : control FSM state (idle, multiply iterating, result held)
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_NAND = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_SHL  = 3'b110,
    OP_MUL  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_OUT  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
//   clk, rst_n    : clock, async active-low reset
//   start         : load operands (iteration begins on the following edge)
//   op_a, op_b    : multiplicand / multiplier, sampled when start is high
//   product       : full 2*WIDTH product, valid in the cycle done is high
//   done          : the final iteration completes at the next rising edge
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               active_q, active_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_next;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    // Partial sum including this cycle's bit; exported so the final
    // iteration's result is available without an extra cycle.
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, op_a};
      mplier_d = op_b;
    end else if (active_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign product = acc_next;
  assign done    = active_q && (cnt_q == LAST);

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake on both sides.
// Single-cycle ops register their result on the accept edge; MUL runs
// through alu_mul_iter and presents its result WIDTH edges after accept.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : request handshake (op1, op2, alu_op)
//   out_valid / out_ready: result handshake (result, flag_z/c/v)
//   busy                 : multiply in progress
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               z_q, z_d, c_q, c_d, v_q, v_d;

  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  alu_op_e            op;
  logic [SW-1:0]      sh_amt;
  logic [WIDTH:0]     add_full, shl_full;
  logic [WIDTH-1:0]   sub_res, alu_res;
  logic               alu_c, alu_v;

  assign op        = alu_op_e'(alu_op);
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q == ST_MULT);
  assign in_ready  = (state_q != ST_MULT) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  // Single-cycle datapath
  always_comb begin
    sh_amt   = op2[SW-1:0];
    add_full = {1'b0, op1} + {1'b0, op2};
    sub_res  = op1 - op2;
    // Extra top bit catches the last bit shifted out; zero for shift 0.
    shl_full = {1'b0, op1} << sh_amt;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (op1[WIDTH-1] == op2[WIDTH-1]) && (alu_res[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_c   = (op1 >= op2);
        alu_v   = (op1[WIDTH-1] != op2[WIDTH-1]) && (sub_res[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_NAND: alu_res = ~(op1 & op2);
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_SHL: begin
        alu_res = shl_full[WIDTH-1:0];
        alu_c   = shl_full[WIDTH];
      end
      default: ;
    endcase
  end

  // Control FSM / result register next-state
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    z_d       = z_q;
    c_d       = c_q;
    v_d       = v_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_OUT: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MULT;
          end else begin
            state_d = ST_OUT;
            res_d   = alu_res;
            z_d     = (alu_res == '0);
            c_d     = alu_c;
            v_d     = alu_v;
          end
        end else if (state_q == ST_OUT && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_MULT: begin
        if (mul_done) begin
          state_d = ST_OUT;
          res_d   = mul_prod[WIDTH-1:0];
          z_d     = (mul_prod[WIDTH-1:0] == '0);
          c_d     = 1'b0;
          v_d     = |mul_prod[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign result = res_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_v = v_q;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .op_a    (op1),
    .op_b    (op2),
    .product (mul_prod),
    .done    (mul_done)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: a WIDTH=16 instance for the main
// directed and random sequences and a WIDTH=8 instance for the narrow
// configuration. Expected values come from an arithmetic reference model.
module tb_seq_alu;

  localparam int W  = 16;
  localparam int W8 = 8;
  localparam logic [2:0] ADD = 3'd0, NAND = 3'd1, SUB = 3'd2, AND_ = 3'd3,
                         OR_ = 3'd4, XOR_ = 3'd5, SHL = 3'd6, MUL = 3'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] op1 = '0, op2 = '0;
  logic [2:0]   alu_op = '0;
  logic         in_ready, out_valid, flag_z, flag_c, flag_v, busy;
  logic [W-1:0] result;

  logic          in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic [W8-1:0] op1_8 = '0, op2_8 = '0;
  logic [2:0]    alu_op8 = '0;
  logic          in_ready8, out_valid8, flag_z8, flag_c8, flag_v8, busy8;
  logic [W8-1:0] result8;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_z(flag_z),
    .flag_c(flag_c), .flag_v(flag_v), .busy(busy)
  );

  seq_alu #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op1(op1_8), .op2(op2_8), .alu_op(alu_op8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .flag_z(flag_z8),
    .flag_c(flag_c8), .flag_v(flag_v8), .busy(busy8)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint sval(input logic [127:0] x, input int w);
    return x[w-1] ? longint'(x[63:0]) - (longint'(1) << w) : longint'(x[63:0]);
  endfunction

  // Returns {z, c, v, result[63:0]}; valid for w <= 32.
  function automatic logic [66:0] model(input int w, input logic [2:0] op,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0] mask, full, r;
    longint       s, lo, hi;
    int           sh;
    logic         c, v;
    mask = (128'd1 << w) - 1;
    lo   = -(longint'(1) << (w - 1));
    hi   = (longint'(1) << (w - 1)) - 1;
    c = 1'b0; v = 1'b0; full = '0;
    case (op)
      ADD: begin
        full = 128'(a) + 128'(b);
        c    = (full > mask);
        s    = sval(128'(a), w) + sval(128'(b), w);
        v    = (s < lo) || (s > hi);
      end
      SUB: begin
        full = 128'(a) - 128'(b);
        c    = (a >= b);
        s    = sval(128'(a), w) - sval(128'(b), w);
        v    = (s < lo) || (s > hi);
      end
      NAND: full = ~(128'(a) & 128'(b));
      AND_: full = 128'(a) & 128'(b);
      OR_:  full = 128'(a) | 128'(b);
      XOR_: full = 128'(a) ^ 128'(b);
      SHL: begin
        sh   = int'(b % 64'(w));
        full = 128'(a) << sh;
        c    = (sh != 0) && (((a >> (w - sh)) & 64'd1) != 0);
      end
      default: begin
        full = 128'(a) * 128'(b);
        v    = (full >> w) != 0;
      end
    endcase
    r = full & mask;
    return {(r == 0), c, v, r[63:0]};
  endfunction

  task automatic chk_res(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [66:0] e;
    e = model(W, op, 64'(a), 64'(b));
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_result"}, 64'(result), e[63:0]);
    chk({tag, "_zcv"}, 64'({flag_z, flag_c, flag_v}), 64'(e[66:64]));
  endtask

  task automatic send(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int g = 0;
    in_valid = 1'b1; alu_op = op; op1 = a; op2 = b;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n, busy_n;
    bit rdy_seen;
    send(tag, op, a, b);
    if (op == MUL) begin
      n = 0; busy_n = 0; rdy_seen = 0;
      while (!out_valid && n < 100) begin
        if (busy) busy_n++;
        if (in_ready) rdy_seen = 1;
        @(posedge clk); #1; n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'(W));
      chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(W));
      chk({tag, "_ready_during_mul"}, 64'(rdy_seen), 64'd0);
    end
    chk_res(tag, op, a, b);
  endtask

  task automatic run8(input string tag, input logic [2:0] op, input logic [W8-1:0] a, input logic [W8-1:0] b);
    logic [66:0] e;
    int n = 0;
    in_valid8 = 1'b1; alu_op8 = op; op1_8 = a; op2_8 = b;
    chk({tag, "_in_ready"}, 64'(in_ready8), 64'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    while (!out_valid8 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, 64'(n), (op == MUL) ? 64'(W8) : 64'd0);
    e = model(W8, op, 64'(a), 64'(b));
    chk({tag, "_result"}, 64'(result8), e[63:0]);
    chk({tag, "_zcv"}, 64'({flag_z8, flag_c8, flag_v8}), 64'(e[66:64]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   rop;
    logic [W-1:0] ra, rb, held;
    logic [2:0]   held_f;

    // Reset state
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({flag_z, flag_c, flag_v}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic / logic directed cases
    run("add_5_3", ADD, 16'd5, 16'd3);
    run("add_ovf", ADD, 16'h7FFF, 16'd1);
    run("add_carry", ADD, 16'hFFFF, 16'd1);
    run("nand", NAND, 16'hFFFF, 16'h00FF);
    run("sub_neg", SUB, 16'd3, 16'd5);
    run("sub_zero", SUB, 16'd5, 16'd5);
    run("sub_ovf", SUB, 16'h8000, 16'd1);
    run("shl_zero", SHL, 16'hABCD, 16'd0);
    run("mul_300", MUL, 16'd300, 16'd300);
    run("mul_small", MUL, 16'd7, 16'd9);

    // Back-to-back with out_ready high
    out_ready = 1'b1;
    in_valid = 1'b1; alu_op = ADD; op1 = 16'd100; op2 = 16'd23;
    @(posedge clk); #1;
    chk_res("b2b_add", ADD, 16'd100, 16'd23);
    chk("b2b_ready1", 64'(in_ready), 64'd1);
    alu_op = XOR_; op1 = 16'hF0F0; op2 = 16'h0FF0;
    @(posedge clk); #1;
    chk_res("b2b_xor", XOR_, 16'hF0F0, 16'h0FF0);
    chk("b2b_ready2", 64'(in_ready), 64'd1);
    alu_op = SHL; op1 = 16'd1; op2 = 16'd15;
    @(posedge clk); #1;
    chk_res("b2b_shl", SHL, 16'd1, 16'd15);
    alu_op = SHL; op1 = 16'hC000; op2 = 16'd1;
    @(posedge clk); #1;
    chk_res("b2b_shl_c", SHL, 16'hC000, 16'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Output stall: result held, new request blocked until release
    out_ready = 1'b0;
    send("stall_first", ADD, 16'hFFF0, 16'h0020);
    held   = result;
    held_f = {flag_z, flag_c, flag_v};
    chk_res("stall_first", ADD, 16'hFFF0, 16'h0020);
    in_valid = 1'b1; alu_op = SUB; op1 = 16'd9; op2 = 16'd4;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_result", 64'(result), 64'(held));
      chk("stall_flags", 64'({flag_z, flag_c, flag_v}), 64'(held_f));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_res("release_sub", SUB, 16'd9, 16'd4);
    @(posedge clk); #1;

    // Randomized ops against the model
    for (int i = 0; i < 120; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(0, 3));
      run("rand", rop, ra, rb);
    end

    // Narrow configuration
    run8("w8_add_5_3", ADD, 8'd5, 8'd3);
    run8("w8_add_ovf", ADD, 8'h7F, 8'd1);
    run8("w8_add_carry", ADD, 8'hFF, 8'd1);
    run8("w8_sub_neg", SUB, 8'd3, 8'd5);
    run8("w8_shl", SHL, 8'hC0, 8'd1);
    run8("w8_mul", MUL, 8'd20, 8'd20);

    // Reset asserted during cycle 5 of a multiply
    send("rst_mul", MUL, 16'd300, 16'd300);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("rst_mul_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mul_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mul_busy", 64'(busy), 64'd0);
    chk("rst_mul_result", 64'(result), 64'd0);
    chk("rst_mul_flags", 64'({flag_z, flag_c, flag_v}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst_add", ADD, 16'd5, 16'd3);
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("post_rst_no_stale", 64'(result), 64'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
